// File: rtl/ara_pkg.sv
// Shared vector-unit types used by the multiplier arbiter.
package ara_pkg;

    localparam int unsigned ELEN  = 64;
    localparam int unsigned ELENB = ELEN / 8;

    typedef logic [ELEN-1:0]  elen_t;
    typedef logic [ELENB-1:0] strb_t;

    typedef enum logic [2:0] {
        VMUL,
        VMULH,
        VMULHU,
        VMULHSU,
        VMACC,
        VNMSAC,
        VMADD,
        VNMSUB
    } ara_op_e;

endpackage

// File: rtl/simd_mul_tag_fifo.sv
// Synchronous tag FIFO with arbitrary depth (pointers wrap modulo Depth).
// Ports: clk_i/rst_i (sync active-high), push_i/data_i write side,
//        pop_i/data_o read side (data_o shows the head), full_o, empty_o,
//        usage_o current occupancy.
module simd_mul_tag_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned DataW = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [DataW-1:0]           data_i,
    input  logic                       pop_i,
    output logic [DataW-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] usage_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [DataW-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Push is refused while full even when a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage array, no reset needed
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/simd_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NumReq
// requesters. Issued requester indices are queued as tags so in-order
// results are routed back to the requester that issued them.
// Ports: clk_i/rst_i (sync active-high); req_* per-requester issue side;
//        mul_* issue and result handshakes with the multiplier; res_* result
//        broadcast with per-requester valid/ready; inflight_o outstanding
//        count; err_o sticky flag for a result arriving with no tag queued.
module simd_mul_arbiter
    import ara_pkg::*;
#(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned MaxInflight = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  ara_op_e                          req_op_i        [NumReq],
    input  elen_t                            req_operand_a_i [NumReq],
    input  elen_t                            req_operand_b_i [NumReq],
    input  elen_t                            req_operand_c_i [NumReq],
    input  strb_t                            req_mask_i      [NumReq],
    output ara_op_e                          mul_op_o,
    output elen_t                            mul_operand_a_o,
    output elen_t                            mul_operand_b_o,
    output elen_t                            mul_operand_c_o,
    output strb_t                            mul_mask_o,
    output logic                             mul_valid_o,
    input  logic                             mul_ready_i,
    input  elen_t                            mul_result_i,
    input  strb_t                            mul_mask_i,
    input  logic                             mul_valid_i,
    output logic                             mul_ready_o,
    output elen_t                            res_result_o,
    output strb_t                            res_mask_o,
    output logic [NumReq-1:0]                res_valid_o,
    input  logic [NumReq-1:0]                res_ready_i,
    output logic [$clog2(MaxInflight+1)-1:0] inflight_o,
    output logic                             err_o
);

    localparam int unsigned TagW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef logic [TagW-1:0] tag_t;

    tag_t        rr_ptr_q;
    tag_t        held_q;
    logic        hold_q;
    tag_t        grant;
    tag_t        head_tag;
    logic        fifo_full;
    logic        fifo_empty;
    logic        issue;
    logic        res_pop;
    logic        found;
    int unsigned idx;

    // Round-robin search from rr_ptr; a stalled offer keeps its grant.
    always_comb begin
        grant = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (!found && req_valid_i[tag_t'(idx)]) begin
                grant = tag_t'(idx);
                found = 1'b1;
            end
        end
        if (hold_q && req_valid_i[held_q]) begin
            grant = held_q;
        end
    end

    assign mul_valid_o     = ~rst_i & (|req_valid_i) & ~fifo_full;
    assign issue           = mul_valid_o & mul_ready_i;
    assign mul_op_o        = req_op_i[grant];
    assign mul_operand_a_o = req_operand_a_i[grant];
    assign mul_operand_b_o = req_operand_b_i[grant];
    assign mul_operand_c_o = req_operand_c_i[grant];
    assign mul_mask_o      = req_mask_i[grant];

    // Only the granted requester sees ready
    always_comb begin
        req_ready_o = '0;
        if (issue) begin
            req_ready_o[grant] = 1'b1;
        end
    end

    // Results go to the head tag; with no tag queued the result is dropped.
    always_comb begin
        res_valid_o = '0;
        if (!rst_i && mul_valid_i && !fifo_empty) begin
            res_valid_o[head_tag] = 1'b1;
        end
    end

    assign mul_ready_o  = ~rst_i & (fifo_empty ? mul_valid_i : res_ready_i[head_tag]);
    assign res_pop      = ~rst_i & mul_valid_i & ~fifo_empty & res_ready_i[head_tag];
    assign res_result_o = mul_result_i;
    assign res_mask_o   = mul_mask_i;

    // Arbitration state and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            held_q   <= '0;
            hold_q   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            hold_q <= mul_valid_o & ~mul_ready_i;
            held_q <= grant;
            if (issue) begin
                rr_ptr_q <= (32'(grant) + 1 >= NumReq) ? '0 : grant + tag_t'(1);
            end
            if (mul_valid_i && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

    simd_mul_tag_fifo #(
        .Depth (MaxInflight),
        .DataW (TagW)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (issue),
        .data_i  (grant),
        .pop_i   (res_pop),
        .data_o  (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (inflight_o)
    );

endmodule

// File: tb/tb_simd_mul_arbiter.sv
// Self-checking bench for simd_mul_arbiter: scoreboard of issued operations
// checked against routed results, plus directed scenario tasks.
module tb_simd_mul_arbiter;
    import ara_pkg::*;

    localparam int unsigned NR  = 2;
    localparam int unsigned MI  = 4;
    localparam int          LAT = 4;

    typedef struct packed {
        int    id;
        elen_t res;
        strb_t mask;
        int    due;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    ara_op_e       req_op   [NR];
    elen_t         req_a    [NR];
    elen_t         req_b    [NR];
    elen_t         req_c    [NR];
    strb_t         req_mask [NR];
    ara_op_e       iss_op;
    elen_t         iss_a;
    elen_t         iss_b;
    elen_t         iss_c;
    strb_t         iss_mask;
    logic          iss_valid;
    logic          iss_ready;
    elen_t         m_result;
    strb_t         m_mask;
    logic          m_valid;
    logic          m_ready;
    elen_t         res_result;
    strb_t         res_mask;
    logic [NR-1:0] res_valid;
    logic [NR-1:0] res_ready;
    logic [2:0]    inflight;
    logic          err;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic auto_mul = 1'b0;
    logic issued = 1'b0;
    int   last_grant = 0;
    ent_t sb [$];
    ent_t pipe [$];
    int   grant_log [$];

    always #5 clk = ~clk;

    simd_mul_arbiter #(
        .NumReq      (NR),
        .MaxInflight (MI)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_op_i        (req_op),
        .req_operand_a_i (req_a),
        .req_operand_b_i (req_b),
        .req_operand_c_i (req_c),
        .req_mask_i      (req_mask),
        .mul_op_o        (iss_op),
        .mul_operand_a_o (iss_a),
        .mul_operand_b_o (iss_b),
        .mul_operand_c_o (iss_c),
        .mul_mask_o      (iss_mask),
        .mul_valid_o     (iss_valid),
        .mul_ready_i     (iss_ready),
        .mul_result_i    (m_result),
        .mul_mask_i      (m_mask),
        .mul_valid_i     (m_valid),
        .mul_ready_o     (m_ready),
        .res_result_o    (res_result),
        .res_mask_o      (res_mask),
        .res_valid_o     (res_valid),
        .res_ready_i     (res_ready),
        .inflight_o      (inflight),
        .err_o           (err)
    );

    task automatic new_payload(input int k);
        req_a[k]    = {$urandom, $urandom};
        req_b[k]    = {$urandom, $urandom};
        req_c[k]    = {$urandom, $urandom};
        req_mask[k] = 8'($urandom);
        req_op[k]   = ara_op_e'(3'($urandom_range(0, 7)));
    endtask

    // One clock: sample handshakes mid-cycle, then update the multiplier model.
    task automatic tick();
        int   g;
        ent_t e;
        logic mhs;
        @(negedge clk);
        issued = 1'b0;
        if (iss_valid && iss_ready) begin
            checks++;
            if ($countones(req_ready) != 1) begin
                failures++;
                $display("FAIL issue_onehot req_ready=%b required exactly one bit", req_ready);
            end
            g = 0;
            for (int k = 0; k < NR; k++) begin
                if (req_ready[k]) g = k;
            end
            checks++;
            if (iss_a !== req_a[g] || iss_b !== req_b[g] || iss_c !== req_c[g] ||
                iss_op !== req_op[g] || iss_mask !== req_mask[g]) begin
                failures++;
                $display("FAIL issue_payload grant=%0d a=%h required %h", g, iss_a, req_a[g]);
            end
            e.id   = g;
            e.res  = req_a[g] * req_b[g] + req_c[g];
            e.mask = req_mask[g];
            e.due  = cyc + LAT;
            sb.push_back(e);
            pipe.push_back(e);
            issued     = 1'b1;
            last_grant = g;
            grant_log.push_back(g);
        end
        for (int k = 0; k < NR; k++) begin
            if (res_valid[k] && res_ready[k]) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL res_unexpected requester=%0d got result with nothing outstanding", k);
                end else begin
                    e = sb.pop_front();
                    if (k != e.id || res_result !== e.res || res_mask !== e.mask) begin
                        failures++;
                        $display("FAIL res_route got req=%0d res=%h mask=%h required req=%0d res=%h mask=%h",
                                 k, res_result, res_mask, e.id, e.res, e.mask);
                    end
                end
            end
        end
        mhs = m_valid && m_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (mhs && pipe.size() > 0) void'(pipe.pop_front());
        if (auto_mul) begin
            if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                m_valid  = 1'b1;
                m_result = pipe[0].res;
                m_mask   = pipe[0].mask;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        req_valid = '0;
        res_ready = '1;
        auto_mul  = 1'b1;
        while (inflight != 0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (inflight !== 3'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL drain inflight=%0d pending=%0d required 0/0", inflight, sb.size());
        end
        auto_mul = 1'b0;
        m_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        iss_ready = 1'b1;
        res_ready = '1;
        m_valid   = 1'b1;
        m_result  = '0;
        m_mask    = '0;
        new_payload(0);
        new_payload(1);
        tick();
        #1;
        checks++;
        if (iss_valid !== 1'b0 || req_ready !== 2'b00 || m_ready !== 1'b0 || res_valid !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs mul_valid=%b req_ready=%b mul_ready=%b res_valid=%b required all 0",
                     iss_valid, req_ready, m_ready, res_valid);
        end
        tick();
        rst       = 1'b0;
        m_valid   = 1'b0;
        req_valid = '0;
        #1;
        checks++;
        if (inflight !== 3'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state inflight=%0d err=%b required 0/0", inflight, err);
        end
    endtask

    task automatic test_alternate();
        int n = 0;
        res_ready = '1;
        iss_ready = 1'b1;
        auto_mul  = 1'b1;
        req_valid = 2'b11;
        grant_log.delete();
        while (grant_log.size() < 8 && n < 200) begin
            tick();
            if (issued) new_payload(last_grant);
            n++;
        end
        req_valid = '0;
        checks++;
        if (grant_log.size() < 8) begin
            failures++;
            $display("FAIL alt_count grants=%0d required 8", grant_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (grant_log[i] != i % 2) begin
                    failures++;
                    $display("FAIL alt_grant idx=%0d got=%0d required %0d", i, grant_log[i], i % 2);
                end
            end
        end
        drain();
    endtask

    task automatic test_hold();
        elen_t a0;
        auto_mul  = 1'b1;
        res_ready = '1;
        iss_ready = 1'b1;
        req_valid = 2'b01;
        tick();
        checks++;
        if (!issued || last_grant != 0) begin
            failures++;
            $display("FAIL hold_pre issued=%b grant=%0d required 1/0", issued, last_grant);
        end
        new_payload(0);
        a0        = req_a[0];
        iss_ready = 1'b0;
        #1;
        checks++;
        if (iss_valid !== 1'b1 || req_ready !== 2'b00 || iss_a !== a0) begin
            failures++;
            $display("FAIL hold_c1 valid=%b ready=%b a=%h required 1/00/%h", iss_valid, req_ready, iss_a, a0);
        end
        tick();
        req_valid = 2'b11;
        #1;
        checks++;
        if (iss_valid !== 1'b1 || req_ready !== 2'b00 || iss_a !== a0) begin
            failures++;
            $display("FAIL hold_c2 valid=%b ready=%b a=%h required 1/00/%h", iss_valid, req_ready, iss_a, a0);
        end
        tick();
        #1;
        checks++;
        if (iss_valid !== 1'b1 || iss_a !== a0 || iss_b !== req_b[0]) begin
            failures++;
            $display("FAIL hold_c3 valid=%b a=%h required 1/%h", iss_valid, iss_a, a0);
        end
        tick();
        iss_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL hold_accept req_ready=%b required 01", req_ready);
        end
        tick();
        new_payload(0);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL hold_next req_ready=%b required 10", req_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_full();
        int n_iss = 0;
        auto_mul  = 1'b0;
        m_valid   = 1'b0;
        res_ready = '0;
        iss_ready = 1'b1;
        req_valid = 2'b01;
        new_payload(0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (issued) begin
                n_iss++;
                new_payload(0);
            end
        end
        checks++;
        if (n_iss != 4 || inflight !== 3'd4 || iss_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_block issued=%0d inflight=%0d mul_valid=%b required 4/4/0", n_iss, inflight, iss_valid);
        end
        res_ready = 2'b01;
        m_valid   = 1'b1;
        m_result  = pipe[0].res;
        m_mask    = pipe[0].mask;
        #1;
        checks++;
        if (m_ready !== 1'b1 || iss_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_nobypass mul_ready=%b mul_valid=%b required 1/0", m_ready, iss_valid);
        end
        tick();
        m_valid = 1'b0;
        #1;
        checks++;
        if (iss_valid !== 1'b1 || inflight !== 3'd3) begin
            failures++;
            $display("FAIL full_refill mul_valid=%b inflight=%0d required 1/3", iss_valid, inflight);
        end
        tick();
        checks++;
        if (!issued || inflight !== 3'd4) begin
            failures++;
            $display("FAIL full_reissue issued=%b inflight=%0d required 1/4", issued, inflight);
        end
        drain();
    endtask

    task automatic test_route();
        auto_mul  = 1'b0;
        res_ready = '0;
        iss_ready = 1'b1;
        req_valid = 2'b10;
        new_payload(1);
        tick();
        req_valid = '0;
        checks++;
        if (!issued || last_grant != 1) begin
            failures++;
            $display("FAIL route_issue issued=%b grant=%0d required 1/1", issued, last_grant);
        end
        res_ready = 2'b01;
        m_valid   = 1'b1;
        m_result  = pipe[0].res;
        m_mask    = pipe[0].mask;
        #1;
        checks++;
        if (m_ready !== 1'b0 || res_valid !== 2'b10) begin
            failures++;
            $display("FAIL route_block mul_ready=%b res_valid=%b required 0/10", m_ready, res_valid);
        end
        tick();
        #1;
        checks++;
        if (m_ready !== 1'b0 || res_valid !== 2'b10 || inflight !== 3'd1) begin
            failures++;
            $display("FAIL route_held mul_ready=%b res_valid=%b inflight=%0d required 0/10/1", m_ready, res_valid, inflight);
        end
        res_ready = 2'b11;
        #1;
        checks++;
        if (m_ready !== 1'b1 || res_valid !== 2'b10) begin
            failures++;
            $display("FAIL route_release mul_ready=%b res_valid=%b required 1/10", m_ready, res_valid);
        end
        tick();
        m_valid = 1'b0;
        #1;
        checks++;
        if (inflight !== 3'd0) begin
            failures++;
            $display("FAIL route_pop inflight=%0d required 0", inflight);
        end
    endtask

    task automatic test_err();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_pre err=%b required 0", err);
        end
        res_ready = '1;
        m_valid   = 1'b1;
        m_result  = 64'hDEAD_BEEF_0000_1234;
        #1;
        checks++;
        if (m_ready !== 1'b1 || res_valid !== 2'b00) begin
            failures++;
            $display("FAIL err_drop mul_ready=%b res_valid=%b required 1/00", m_ready, res_valid);
        end
        tick();
        m_valid = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_set err=%b required 1", err);
        end
        repeat (3) tick();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky err=%b required 1", err);
        end
    endtask

    task automatic test_reset_mid();
        auto_mul  = 1'b0;
        res_ready = '0;
        iss_ready = 1'b1;
        req_valid = 2'b11;
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (issued) new_payload(last_grant);
        end
        req_valid = '0;
        checks++;
        if (inflight !== 3'd3 || grant_log.size() != 3 || last_grant != 0) begin
            failures++;
            $display("FAIL rstmid_pre inflight=%0d grants=%0d last=%0d required 3/3/0", inflight, grant_log.size(), last_grant);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        pipe.delete();
        #1;
        checks++;
        if (inflight !== 3'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear inflight=%0d err=%b required 0/0", inflight, err);
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_grant req_ready=%b required 01", req_ready);
        end
        tick();
        drain();
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_hold();
        test_full();
        test_route();
        test_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
